// File: rtl/aha_xgcd_perf_monitor_pkg.sv
// Shared definitions for the XGCD performance monitor.
// Contents: register map, STATUS/CTRL field positions, channel FSM states and the default counter width.
package aha_xgcd_perf_monitor_pkg;

    localparam int CNT_W_DEFAULT = 32;

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_IRQ_EN = 32'h04;
    localparam logic [31:0] OFF_STATUS = 32'h08;
    localparam logic [31:0] OFF_STATE  = 32'h0C;
    localparam logic [31:0] OFF_LAST0  = 32'h10;
    localparam logic [31:0] OFF_MIN0   = 32'h14;
    localparam logic [31:0] OFF_MAX0   = 32'h18;
    localparam logic [31:0] OFF_COUNT0 = 32'h1C;
    localparam logic [31:0] OFF_LAST1  = 32'h20;
    localparam logic [31:0] OFF_MIN1   = 32'h24;
    localparam logic [31:0] OFF_MAX1   = 32'h28;
    localparam logic [31:0] OFF_COUNT1 = 32'h2C;

    localparam int CTRL_EN_LSB     = 0;
    localparam int CTRL_CLR_LSB    = 8;
    localparam int STATUS_DONE_LSB = 0;
    localparam int STATUS_INT_LSB  = 2;
    localparam int STATUS_ERR_LSB  = 4;
    localparam int STATUS_W        = 6;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chanState_e;

endpackage

// File: rtl/aha_xgcd_perf_monitor_channel.sv
// One XGCD channel: rising-edge detectors, IDLE/RUN latency FSM, saturating counter
// and the LAST/MIN/MAX/COUNT statistics for that channel.
module aha_xgcd_perf_monitor_channel
    import aha_xgcd_perf_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clrStats_i,
    input  logic             start_i,
    input  logic             done_i,
    input  logic             int_i,
    output logic             running_o,
    output logic             doneEvt_o,
    output logic             intEvt_o,
    output logic             errEvt_o,
    output logic [CNT_W-1:0] last_o,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o,
    output logic [31:0]      count_o
);

    chanState_e       state_q;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;
    logic [31:0]      count_q;
    logic             startPrev_q;
    logic             donePrev_q;
    logic             intPrev_q;
    logic             startEdge;
    logic             doneEdge;

    assign startEdge = start_i & ~startPrev_q & en_i;
    assign doneEdge  = done_i & ~donePrev_q;
    assign intEvt_o  = int_i & ~intPrev_q;
    assign doneEvt_o = (state_q == CH_RUN) & doneEdge;
    assign errEvt_o  = (state_q == CH_RUN) ? (startEdge & ~doneEdge) : (doneEdge & ~startEdge);

    assign running_o = (state_q == CH_RUN);
    assign last_o    = last_q;
    assign min_o     = min_q;
    assign max_o     = max_q;
    assign count_o   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startPrev_q <= 1'b0;
            donePrev_q  <= 1'b0;
            intPrev_q   <= 1'b0;
        end else begin
            startPrev_q <= start_i;
            donePrev_q  <= done_i;
            intPrev_q   <= int_i;
        end
    end

    // counter_q holds the cycles elapsed since the start edge, so on the done
    // edge it already equals the latency and can be latched directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CH_IDLE;
            counter_q <= '0;
            last_q    <= '0;
            min_q     <= '1;
            max_q     <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (startEdge) begin
                        state_q   <= CH_RUN;
                        counter_q <= CNT_W'(1);
                    end
                end
                CH_RUN: begin
                    if (doneEdge) begin
                        last_q  <= counter_q;
                        min_q   <= (counter_q < min_q) ? counter_q : min_q;
                        max_q   <= (counter_q > max_q) ? counter_q : max_q;
                        count_q <= count_q + 32'd1;
                        if (startEdge) begin
                            counter_q <= CNT_W'(1);
                        end else begin
                            state_q <= CH_IDLE;
                        end
                    end else if (startEdge) begin
                        counter_q <= CNT_W'(1);
                    end else if (counter_q != '1) begin
                        counter_q <= counter_q + 1'b1;
                    end
                end
                default: state_q <= CH_IDLE;
            endcase
            if (clrStats_i) begin
                last_q  <= '0;
                min_q   <= '1;
                max_q   <= '0;
                count_q <= '0;
            end
        end
    end

endmodule

// File: rtl/aha_xgcd_perf_monitor.sv
// APB-slave latency monitor for the two XGCD channels, with STATUS/IRQ_EN
// registers aggregated into a single registered PERF_IRQ line.
module aha_xgcd_perf_monitor
    import aha_xgcd_perf_monitor_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              XGCD0_START,
    input  logic              XGCD1_START,
    input  logic              XGCD0_DONE,
    input  logic              XGCD1_DONE,
    input  logic              XGCD0_INT,
    input  logic              XGCD1_INT,
    output logic              PERF_IRQ
);

    logic                access;
    logic                wrEn;
    logic                mapped;
    logic                roHit;
    logic [31:0]         addrWord;
    logic [31:0]         rdata;
    logic [1:0]          en_q, en_d;
    logic [1:0]          clrStats;
    logic [STATUS_W-1:0] irqEn_q, irqEn_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [STATUS_W-1:0] hwSet, w1c;
    logic                perfIrq_q;
    logic [1:0]          startLvl, doneLvl, intLvl;
    logic [1:0]          running, doneEvt, intEvt, errEvt;
    logic [CNT_W-1:0]    lastVal [2];
    logic [CNT_W-1:0]    minVal [2];
    logic [CNT_W-1:0]    maxVal [2];
    logic [31:0]         countVal [2];
    logic                unusedBits;

    assign startLvl = {XGCD1_START, XGCD0_START};
    assign doneLvl  = {XGCD1_DONE, XGCD0_DONE};
    assign intLvl   = {XGCD1_INT, XGCD0_INT};

    for (genvar g = 0; g < 2; g++) begin : gCh
        aha_xgcd_perf_monitor_channel #(.CNT_W(CNT_W)) uCh (
            .clk        (CLK),
            .rst        (RESET),
            .en_i       (en_q[g]),
            .clrStats_i (clrStats[g]),
            .start_i    (startLvl[g]),
            .done_i     (doneLvl[g]),
            .int_i      (intLvl[g]),
            .running_o  (running[g]),
            .doneEvt_o  (doneEvt[g]),
            .intEvt_o   (intEvt[g]),
            .errEvt_o   (errEvt[g]),
            .last_o     (lastVal[g]),
            .min_o      (minVal[g]),
            .max_o      (maxVal[g]),
            .count_o    (countVal[g])
        );
    end

    assign access   = PSEL & PENABLE;
    assign addrWord = 32'(PADDR) & ~32'h3;
    assign mapped   = (addrWord <= OFF_COUNT1);
    assign roHit    = (addrWord >= OFF_STATE);
    assign PSLVERR  = access & (~mapped | (PWRITE & roHit));
    assign wrEn     = access & PWRITE & ~PSLVERR;
    assign PREADY   = 1'b1;
    assign PRDATA   = access ? rdata : 32'h0;
    assign PERF_IRQ = perfIrq_q;
    assign hwSet    = {errEvt, intEvt, doneEvt};
    assign unusedBits = ^{PWDATA[31:10], PWDATA[7:6]};

    // A hardware set is ORed in after the W1C mask so it always survives a clear.
    always_comb begin
        en_d     = en_q;
        irqEn_d  = irqEn_q;
        clrStats = '0;
        w1c      = '0;
        if (wrEn) begin
            case (addrWord)
                OFF_CTRL: begin
                    en_d     = PWDATA[CTRL_EN_LSB +: 2];
                    clrStats = PWDATA[CTRL_CLR_LSB +: 2];
                end
                OFF_IRQ_EN: irqEn_d = PWDATA[STATUS_W-1:0];
                OFF_STATUS: w1c     = PWDATA[STATUS_W-1:0];
                default: ;
            endcase
        end
        status_d = (status_q & ~w1c) | hwSet;
    end

    always_comb begin
        rdata = 32'h0;
        case (addrWord)
            OFF_CTRL:   rdata = {30'h0, en_q};
            OFF_IRQ_EN: rdata = {{(32-STATUS_W){1'b0}}, irqEn_q};
            OFF_STATUS: rdata = {{(32-STATUS_W){1'b0}}, status_q};
            OFF_STATE:  rdata = {30'h0, running};
            OFF_LAST0:  rdata = 32'(lastVal[0]);
            OFF_MIN0:   rdata = 32'(minVal[0]);
            OFF_MAX0:   rdata = 32'(maxVal[0]);
            OFF_COUNT0: rdata = countVal[0];
            OFF_LAST1:  rdata = 32'(lastVal[1]);
            OFF_MIN1:   rdata = 32'(minVal[1]);
            OFF_MAX1:   rdata = 32'(maxVal[1]);
            OFF_COUNT1: rdata = countVal[1];
            default:    rdata = 32'h0;
        endcase
    end

    // PERF_IRQ is computed from next-state values so it rises together with the status bit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en_q      <= '0;
            irqEn_q   <= '0;
            status_q  <= '0;
            perfIrq_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            irqEn_q   <= irqEn_d;
            status_q  <= status_d;
            perfIrq_q <= |(status_d & irqEn_d);
        end
    end

endmodule

// File: tb/tb_aha_xgcd_perf_monitor.sv
// Bench for aha_xgcd_perf_monitor: a reset register table, directed latency/IRQ/W1C/reset
// sequences, and randomized traffic checked against a timestamp-based reference model.
module tb_aha_xgcd_perf_monitor;

    logic        CLK, RESET, PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, PERF_IRQ;
    logic        XGCD0_START, XGCD1_START, XGCD0_DONE, XGCD1_DONE, XGCD0_INT, XGCD1_INT;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: latencies come from cycle timestamps, not a running counter.
    longint      cyc;
    longint      mStartCyc [2];
    logic [1:0]  mRun, mEn, mPrevS, mPrevD, mPrevI;
    logic [5:0]  mIrqEn, mStatus;
    logic        mIrq;
    logic [31:0] mLast [2];
    logic [31:0] mMin [2];
    logic [31:0] mMax [2];
    logic [31:0] mCount [2];

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic        err;
    } regVec_t;

    regVec_t resetTable [13];

    aha_xgcd_perf_monitor dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .XGCD0_START (XGCD0_START),
        .XGCD1_START (XGCD1_START),
        .XGCD0_DONE  (XGCD0_DONE),
        .XGCD1_DONE  (XGCD1_DONE),
        .XGCD0_INT   (XGCD0_INT),
        .XGCD1_INT   (XGCD1_INT),
        .PERF_IRQ    (PERF_IRQ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mRun = '0; mEn = '0; mPrevS = '0; mPrevD = '0; mPrevI = '0;
        mIrqEn = '0; mStatus = '0; mIrq = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            mStartCyc[ch] = 0;
            mLast[ch] = 32'h0; mMin[ch] = 32'hFFFF_FFFF; mMax[ch] = 32'h0; mCount[ch] = 32'h0;
        end
    endtask

    function automatic logic modelErr(input logic [11:0] addr, input logic wr);
        logic [11:0] a;
        a = addr & 12'hFFC;
        return (a > 12'h02C) || (wr && a >= 12'h00C);
    endfunction

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        case (addr & 12'hFFC)
            12'h000: return {30'h0, mEn};
            12'h004: return {26'h0, mIrqEn};
            12'h008: return {26'h0, mStatus};
            12'h00C: return {30'h0, mRun};
            12'h010: return mLast[0];
            12'h014: return mMin[0];
            12'h018: return mMax[0];
            12'h01C: return mCount[0];
            12'h020: return mLast[1];
            12'h024: return mMin[1];
            12'h028: return mMax[1];
            12'h02C: return mCount[1];
            default: return 32'h0;
        endcase
    endfunction

    // Advances the model by one clock using the inputs currently driven.
    task automatic modelStep();
        logic [1:0] s, d, i, se, de, ie, clr, newEn;
        logic [5:0] set, w1c, newIrqEn;
        logic       wr;
        longint     n;
        if (RESET) begin
            modelReset();
            cyc++;
            return;
        end
        s = {XGCD1_START, XGCD0_START};
        d = {XGCD1_DONE, XGCD0_DONE};
        i = {XGCD1_INT, XGCD0_INT};
        se = s & ~mPrevS & mEn;
        de = d & ~mPrevD;
        ie = i & ~mPrevI;
        wr = PSEL & PENABLE & PWRITE & !modelErr(PADDR, 1'b1);
        clr = '0; w1c = '0; set = '0; newEn = mEn; newIrqEn = mIrqEn;
        if (wr) begin
            case (PADDR & 12'hFFC)
                12'h000: begin newEn = PWDATA[1:0]; clr = PWDATA[9:8]; end
                12'h004: newIrqEn = PWDATA[5:0];
                12'h008: w1c = PWDATA[5:0];
                default: ;
            endcase
        end
        set[3:2] = ie;
        for (int ch = 0; ch < 2; ch++) begin
            if (mRun[ch]) begin
                if (de[ch]) begin
                    n = cyc - mStartCyc[ch];
                    mLast[ch] = 32'(n);
                    if (32'(n) < mMin[ch]) mMin[ch] = 32'(n);
                    if (32'(n) > mMax[ch]) mMax[ch] = 32'(n);
                    mCount[ch] = mCount[ch] + 1;
                    set[ch] = 1'b1;
                    mRun[ch] = se[ch];
                    mStartCyc[ch] = cyc;
                end else if (se[ch]) begin
                    mStartCyc[ch] = cyc;
                    set[4+ch] = 1'b1;
                end
            end else begin
                if (se[ch]) begin
                    mRun[ch] = 1'b1;
                    mStartCyc[ch] = cyc;
                end else if (de[ch]) begin
                    set[4+ch] = 1'b1;
                end
            end
            if (clr[ch]) begin
                mLast[ch] = 32'h0; mMin[ch] = 32'hFFFF_FFFF; mMax[ch] = 32'h0; mCount[ch] = 32'h0;
            end
        end
        mStatus = (mStatus & ~w1c) | set;
        mEn = newEn;
        mIrqEn = newIrqEn;
        mIrq = |(mStatus & mIrqEn);
        mPrevS = s; mPrevD = d; mPrevI = i;
        cyc++;
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge CLK);
        #1;
        checkOutput("perf_irq", {31'h0, PERF_IRQ}, {31'h0, mIrq});
    endtask

    task automatic apbRead(input logic [11:0] addr, output logic [31:0] data, output logic err,
                           output logic [31:0] expData, output logic expErr);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PWDATA = 32'h0;
        applyStimulus();
        PENABLE = 1'b1;
        #1;
        data = PRDATA; err = PSLVERR;
        expData = modelRead(addr); expErr = modelErr(addr, 1'b0);
        applyStimulus();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apbWrite(input logic [11:0] addr, input logic [31:0] data, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        applyStimulus();
        PENABLE = 1'b1;
        #1;
        err = PSLVERR;
        applyStimulus();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic readConst(input logic [11:0] addr, input logic [31:0] expected, input string name);
        logic [31:0] d, ed;
        logic e, ee;
        apbRead(addr, d, e, ed, ee);
        checkOutput(name, d, expected);
    endtask

    task automatic writeOk(input logic [11:0] addr, input logic [31:0] data, input string name);
        logic e;
        apbWrite(addr, data, e);
        checkOutput(name, {31'h0, e}, 32'h0);
    endtask

    task automatic setLevel(input int ch, input logic st, input logic dn);
        if (ch == 0) begin XGCD0_START = st; XGCD0_DONE = dn; end
        else begin XGCD1_START = st; XGCD1_DONE = dn; end
    endtask

    task automatic runOp(input int ch, input int len);
        setLevel(ch, 1'b1, 1'b0);
        applyStimulus();
        repeat (len - 1) applyStimulus();
        setLevel(ch, 1'b1, 1'b1);
        applyStimulus();
        setLevel(ch, 1'b0, 1'b0);
        applyStimulus();
    endtask

    initial begin
        logic [31:0] d, ed;
        logic        e, ee;
        logic [11:0] a;
        int          r;

        cyc = 0;
        modelReset();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        XGCD0_START = 0; XGCD1_START = 0; XGCD0_DONE = 0; XGCD1_DONE = 0; XGCD0_INT = 0; XGCD1_INT = 0;
        RESET = 1'b1;

        for (int k = 0; k < 12; k++) begin
            resetTable[k].addr = 12'(k * 4);
            resetTable[k].data = (k == 5 || k == 9) ? 32'hFFFF_FFFF : 32'h0;
            resetTable[k].err  = 1'b0;
        end
        resetTable[12] = '{addr: 12'h040, data: 32'h0, err: 1'b1};

        @(posedge CLK);
        #1;
        applyStimulus();
        RESET = 1'b0;
        applyStimulus();

        $display("[TB] reset register table");
        checkOutput("reset perf_irq", {31'h0, PERF_IRQ}, 32'h0);
        checkOutput("idle pslverr", {31'h0, PSLVERR}, 32'h0);
        checkOutput("idle prdata", PRDATA, 32'h0);
        for (int k = 0; k < 13; k++) begin
            apbRead(resetTable[k].addr, d, e, ed, ee);
            checkOutput($sformatf("reset rd 0x%03h", resetTable[k].addr), d, resetTable[k].data);
            checkOutput($sformatf("reset err 0x%03h", resetTable[k].addr), {31'h0, e}, {31'h0, resetTable[k].err});
        end

        $display("[TB] ch0 latency 100 and IRQ");
        writeOk(12'h000, 32'h3, "wr ctrl");
        writeOk(12'h004, 32'h1, "wr irq_en");
        XGCD0_START = 1'b1;
        applyStimulus();
        repeat (99) applyStimulus();
        checkOutput("t2 irq before done", {31'h0, PERF_IRQ}, 32'h0);
        XGCD0_DONE = 1'b1;
        applyStimulus();
        checkOutput("t2 irq at t+101", {31'h0, PERF_IRQ}, 32'h1);
        XGCD0_START = 1'b0; XGCD0_DONE = 1'b0;
        readConst(12'h010, 32'd100, "t2 last0");
        readConst(12'h014, 32'd100, "t2 min0");
        readConst(12'h018, 32'd100, "t2 max0");
        readConst(12'h01C, 32'd1, "t2 count0");
        readConst(12'h008, 32'h01, "t2 status");
        readConst(12'h00C, 32'h0, "t2 state");
        writeOk(12'h008, 32'h1, "t2 w1c");
        checkOutput("t2 irq after w1c", {31'h0, PERF_IRQ}, 32'h0);

        $display("[TB] ch1 three ops");
        runOp(1, 50);
        runOp(1, 20);
        runOp(1, 80);
        readConst(12'h020, 32'd80, "t3 last1");
        readConst(12'h024, 32'd20, "t3 min1");
        readConst(12'h028, 32'd80, "t3 max1");
        readConst(12'h02C, 32'd3, "t3 count1");

        $display("[TB] restart and stray done");
        XGCD0_START = 1'b1;
        applyStimulus();
        XGCD0_START = 1'b0;
        repeat (9) applyStimulus();
        XGCD0_START = 1'b1;
        applyStimulus();
        readConst(12'h00C, 32'h1, "t4 state running");
        repeat (27) applyStimulus();
        XGCD0_DONE = 1'b1;
        applyStimulus();
        XGCD0_START = 1'b0; XGCD0_DONE = 1'b0;
        readConst(12'h010, 32'd30, "t4 last0");
        readConst(12'h014, 32'd30, "t4 min0");
        readConst(12'h018, 32'd100, "t4 max0");
        readConst(12'h008, 32'h13, "t4 status err0");
        XGCD1_DONE = 1'b1;
        applyStimulus();
        XGCD1_DONE = 1'b0;
        applyStimulus();
        readConst(12'h008, 32'h33, "t4 status err1");
        readConst(12'h02C, 32'd3, "t4 count1");

        $display("[TB] slave errors and CLR_STATS");
        apbWrite(12'h010, 32'h1234, e);
        checkOutput("t5 ro write err", {31'h0, e}, 32'h1);
        readConst(12'h010, 32'd30, "t5 last0 kept");
        apbRead(12'h040, d, e, ed, ee);
        checkOutput("t5 unmapped err", {31'h0, e}, 32'h1);
        checkOutput("t5 unmapped data", d, 32'h0);
        XGCD0_START = 1'b1;
        applyStimulus();
        repeat (5) applyStimulus();
        writeOk(12'h000, 32'h103, "t5 clr write");
        readConst(12'h014, 32'hFFFF_FFFF, "t5 min0 cleared");
        readConst(12'h01C, 32'h0, "t5 count0 cleared");
        readConst(12'h010, 32'h0, "t5 last0 cleared");
        repeat (26) applyStimulus();
        XGCD0_DONE = 1'b1;
        applyStimulus();
        XGCD0_START = 1'b0; XGCD0_DONE = 1'b0;
        readConst(12'h010, 32'd40, "t5 last0");
        readConst(12'h014, 32'd40, "t5 min0");
        readConst(12'h018, 32'd40, "t5 max0");
        readConst(12'h01C, 32'd1, "t5 count0");
        readConst(12'h000, 32'h3, "t5 ctrl");

        $display("[TB] set beats W1C, reset mid-run");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'h8;
        applyStimulus();
        PENABLE = 1'b1;
        XGCD1_INT = 1'b1;
        applyStimulus();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        readConst(12'h008, 32'h3B, "t6 int1 survives w1c");
        writeOk(12'h008, 32'h8, "t6 w1c int1");
        readConst(12'h008, 32'h33, "t6 int1 cleared");
        XGCD1_INT = 1'b0;
        XGCD0_START = 1'b1;
        applyStimulus();
        repeat (5) applyStimulus();
        XGCD0_START = 1'b0;
        RESET = 1'b1;
        #1;
        checkOutput("t6 async reset irq", {31'h0, PERF_IRQ}, 32'h0);
        applyStimulus();
        RESET = 1'b0;
        applyStimulus();
        readConst(12'h00C, 32'h0, "t6 state after reset");
        readConst(12'h010, 32'h0, "t6 last0 after reset");
        readConst(12'h008, 32'h0, "t6 status after reset");

        $display("[TB] randomized traffic against model");
        writeOk(12'h000, 32'h3, "rnd en");
        writeOk(12'h004, 32'h3F, "rnd irq_en");
        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                d = $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) d = d | ($urandom & 32'h300);
                writeOk(12'h000, d, "rnd ctrl err");
            end else if (r == 1) begin
                writeOk(12'h008, $urandom & 32'h3F, "rnd w1c err");
            end else if (r == 2) begin
                writeOk(12'h004, $urandom & 32'h3F, "rnd irq_en err");
            end else if (r == 3) begin
                a = 12'($urandom_range(0, 13) * 4);
                apbRead(a, d, e, ed, ee);
                checkOutput($sformatf("rnd rd 0x%03h", a), d, ed);
                checkOutput($sformatf("rnd err 0x%03h", a), {31'h0, e}, {31'h0, ee});
            end else begin
                if ($urandom_range(0, 5) == 0) XGCD0_START = ~XGCD0_START;
                if ($urandom_range(0, 5) == 0) XGCD1_START = ~XGCD1_START;
                if ($urandom_range(0, 5) == 0) XGCD0_DONE = ~XGCD0_DONE;
                if ($urandom_range(0, 5) == 0) XGCD1_DONE = ~XGCD1_DONE;
                if ($urandom_range(0, 9) == 0) XGCD0_INT = ~XGCD0_INT;
                if ($urandom_range(0, 9) == 0) XGCD1_INT = ~XGCD1_INT;
                applyStimulus();
            end
        end
        for (int k = 0; k < 12; k++) begin
            a = 12'(k * 4);
            apbRead(a, d, e, ed, ee);
            checkOutput($sformatf("final rd 0x%03h", a), d, ed);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
